// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports, two write lanes
// (lane 1 is younger and wins collisions), write-through bypass, optional
// hardwired-zero r0, per-register busy scoreboard and a bulk-clear sequencer
// that zeroes one register per cycle.
module regfile_mp #(
  parameter int DATAWIDTH = 32,
  parameter int ADDRWIDTH = 5,
  parameter int NREAD     = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wen0,
  input  logic [ADDRWIDTH-1:0]           waddr0,
  input  logic [DATAWIDTH-1:0]           wdata0,
  input  logic                           wen1,
  input  logic [ADDRWIDTH-1:0]           waddr1,
  input  logic [DATAWIDTH-1:0]           wdata1,
  input  logic [NREAD*ADDRWIDTH-1:0]     raddr,
  output logic [NREAD*DATAWIDTH-1:0]     rdata,
  output logic [NREAD-1:0]               rbusy,
  input  logic                           alloc,
  input  logic [ADDRWIDTH-1:0]           alloc_addr,
  input  logic                           clear_req,
  output logic                           clear_busy,
  output logic                           clear_done
);

  localparam int DEPTH = 1 << ADDRWIDTH;
  localparam logic [ADDRWIDTH-1:0] LAST = ADDRWIDTH'(DEPTH - 1);
  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [ADDRWIDTH-1:0]   cnt;
  logic [DATAWIDTH-1:0]   regs [DEPTH];
  logic [DEPTH-1:0]       busy;
  logic                   idle;
  logic                   w0_ok;
  logic                   w1_ok;
  logic                   al_ok;

  assign idle = (state == IDLE);

  // Writes and allocations only take effect in IDLE; r0 is immutable when hardwired.
  assign w0_ok = idle && wen0 && !(ZR && waddr0 == '0);
  assign w1_ok = idle && wen1 && !(ZR && waddr1 == '0);
  assign al_ok = idle && alloc && !(ZR && alloc_addr == '0);

  // Clear sequencer state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Clear sequencer next state and status outputs; done fires on the last sweep cycle.
  always_comb begin
    state_nxt  = state;
    clear_busy = 1'b0;
    clear_done = 1'b0;
    case (state)
      IDLE: begin
        if (clear_req) state_nxt = CLEAR;
      end
      CLEAR: begin
        clear_busy = 1'b1;
        if (cnt == LAST) begin
          clear_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sweep counter: walks 0..DEPTH-1 during CLEAR, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n)              cnt <= '0;
    else if (state == CLEAR) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    else                     cnt <= '0;
  end

  // Storage: lane 1 is applied after lane 0 so it wins same-address collisions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (state == CLEAR) begin
      regs[cnt] <= '0;
    end else begin
      if (w0_ok) regs[waddr0] <= wdata0;
      if (w1_ok) regs[waddr1] <= wdata1;
    end
  end

  // Scoreboard: retiring writes clear busy, a same-cycle allocation re-sets it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (state == CLEAR) begin
      busy[cnt] <= 1'b0;
    end else begin
      if (w0_ok) busy[waddr0]     <= 1'b0;
      if (w1_ok) busy[waddr1]     <= 1'b0;
      if (al_ok) busy[alloc_addr] <= 1'b1;
    end
  end

  // Read ports: zero register first, then younger lane, older lane, stored value.
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [ADDRWIDTH-1:0] a;
    logic                 hit0;
    logic                 hit1;
    logic                 is_zero;

    assign a       = raddr[k*ADDRWIDTH +: ADDRWIDTH];
    assign is_zero = ZR && (a == '0);
    assign hit0    = BP && idle && wen0 && (waddr0 == a);
    assign hit1    = BP && idle && wen1 && (waddr1 == a);

    assign rdata[k*DATAWIDTH +: DATAWIDTH] = is_zero ? '0 :
                                             hit1    ? wdata1 :
                                             hit0    ? wdata0 : regs[a];

    assign rbusy[k] = !idle   ? 1'b1 :
                      is_zero ? 1'b0 : (busy[a] && !(hit0 || hit1));
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, randomized traffic against a
// behavioural model, and hand sequences for reset, bulk clear and reset mid-clear.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic        wen0, wen1, alloc, clear_req;
  logic [4:0]  waddr0, waddr1, alloc_addr;
  logic [31:0] wdata0, wdata1;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        clear_busy, clear_done;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic        m_busy [32];
  bit          m_clear;
  int          m_swept;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .wen0(wen0), .waddr0(waddr0), .wdata0(wdata0),
    .wen1(wen1), .waddr1(waddr1), .wdata1(wdata1),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
    .alloc(alloc), .alloc_addr(alloc_addr),
    .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        w0; logic [4:0] a0; logic [31:0] d0;
    logic        w1; logic [4:0] a1; logic [31:0] d1;
    logic        al; logic [4:0] aa;
    logic [4:0]  r0; logic [4:0] r1;
    logic [31:0] e0; logic [31:0] e1; logic [1:0] eb;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic set_idle();
    wen0 = 0; waddr0 = '0; wdata0 = '0;
    wen1 = 0; waddr1 = '0; wdata1 = '0;
    alloc = 0; alloc_addr = '0; clear_req = 0;
  endtask

  task automatic set_rd(input logic [4:0] p0, input logic [4:0] p1);
    raddr = {p1, p0};
  endtask

  // Expected read value from the architectural rules.
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (a == 0) return '0;
    if (!m_clear && wen1 && waddr1 == a) return wdata1;
    if (!m_clear && wen0 && waddr0 == a) return wdata0;
    return m_regs[a];
  endfunction

  function automatic logic m_rb(input logic [4:0] a);
    if (m_clear) return 1'b1;
    if (a == 0) return 1'b0;
    if ((wen0 && waddr0 == a) || (wen1 && waddr1 == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      m_clear = 0; m_swept = 0;
    end else if (m_clear) begin
      m_regs[m_swept] = '0;
      m_busy[m_swept] = 1'b0;
      m_swept++;
      if (m_swept == 32) m_clear = 0;
    end else begin
      if (wen0 && waddr0 != 0) begin m_regs[waddr0] = wdata0; m_busy[waddr0] = 1'b0; end
      if (wen1 && waddr1 != 0) begin m_regs[waddr1] = wdata1; m_busy[waddr1] = 1'b0; end
      if (alloc && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
      if (clear_req) begin m_clear = 1; m_swept = 0; end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic chk_model(input string nm);
    for (int k = 0; k < 2; k++) begin
      chk({nm, "_rdata"}, rdata[k*32 +: 32], m_rd(raddr[k*5 +: 5]));
      chk({nm, "_rbusy"}, 32'(rbusy[k]), 32'(m_rb(raddr[k*5 +: 5])));
    end
    chk({nm, "_clear_busy"}, 32'(clear_busy), 32'(m_clear));
    chk({nm, "_clear_done"}, 32'(clear_done), 32'(m_clear && m_swept == 31));
  endtask

  initial begin
    set_idle();
    set_rd(5'd0, 5'd0);
    rst_n = 0;
    @(negedge clk);
    tick();
    rst_n = 1;

    // Reset state
    set_rd(5'd3, 5'd31);
    #1;
    chk("rst_rdata0", rdata[31:0], 32'h0);
    chk("rst_rdata1", rdata[63:32], 32'h0);
    chk("rst_rbusy", 32'(rbusy), 32'h0);
    chk("rst_clear_busy", 32'(clear_busy), 32'h0);
    chk("rst_clear_done", 32'(clear_done), 32'h0);

    // Directed vectors: collision, r0, scoreboard
    tbl[0]  = '{1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 5'd5, 5'd0, 32'h22, 32'h0, 2'b00};
    tbl[1]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd5, 5'd5, 32'h22, 32'h22, 2'b00};
    tbl[2]  = '{1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
    tbl[3]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h22, 2'b00};
    tbl[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h0, 32'h0, 2'b00};
    tbl[5]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd5, 32'h0, 32'h22, 2'b01};
    tbl[6]  = '{1'b1, 5'd7, 32'h5, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7, 32'h5, 32'h5, 2'b00};
    tbl[7]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h5, 32'h0, 2'b00};
    tbl[8]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h9, 1'b1, 5'd7, 5'd7, 5'd7, 32'h9, 32'h9, 2'b00};
    tbl[9]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h9, 32'h0, 2'b01};
    tbl[10] = '{1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd4, 32'hBBBB, 1'b0, 5'd0, 5'd3, 5'd4, 32'hAAAA, 32'hBBBB, 2'b00};
    tbl[11] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 5'd7, 5'd3, 32'h77, 32'hAAAA, 2'b00};

    for (int i = 0; i < 12; i++) begin
      wen0 = tbl[i].w0; waddr0 = tbl[i].a0; wdata0 = tbl[i].d0;
      wen1 = tbl[i].w1; waddr1 = tbl[i].a1; wdata1 = tbl[i].d1;
      alloc = tbl[i].al; alloc_addr = tbl[i].aa; clear_req = 0;
      set_rd(tbl[i].r0, tbl[i].r1);
      #1;
      chk($sformatf("vec%0d_rdata0", i), rdata[31:0], tbl[i].e0);
      chk($sformatf("vec%0d_rdata1", i), rdata[63:32], tbl[i].e1);
      chk($sformatf("vec%0d_rbusy", i), 32'(rbusy), 32'(tbl[i].eb));
      chk($sformatf("vec%0d_clear_busy", i), 32'(clear_busy), 32'h0);
      tick();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      wen0 = 1'($urandom); wen1 = 1'($urandom); alloc = 1'($urandom);
      waddr0 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      waddr1 = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      alloc_addr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wdata0 = $urandom; wdata1 = $urandom;
      clear_req = ($urandom_range(0, 79) == 0);
      set_rd(($urandom_range(0, 1) != 0) ? waddr0 : 5'($urandom_range(0, 7)), 5'($urandom));
      #1;
      chk_model("rand");
      tick();
    end

    // Reset after random traffic: every register reads 0
    set_idle();
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(31 - a));
      #1;
      chk($sformatf("t1_rdata_r%0d", a), rdata[31:0], 32'h0);
      chk($sformatf("t1_rbusy_r%0d", a), 32'(rbusy), 32'h0);
      chk("t1_clear_busy", 32'(clear_busy), 32'h0);
      tick();
    end

    // Bulk clear: fill, clear, writes during CLEAR are lost
    for (int i = 0; i < 16; i++) begin
      wen0 = 1; waddr0 = 5'(2 * i);     wdata0 = 32'hA5A5A5A5;
      wen1 = 1; waddr1 = 5'(2 * i + 1); wdata1 = 32'hA5A5A5A5;
      tick();
    end
    set_idle();
    clear_req = 1;
    tick();
    clear_req = 0;
    for (int i = 1; i <= 32; i++) begin
      wen0 = 1; waddr0 = 5'd31; wdata0 = 32'h1234;
      alloc = 1; alloc_addr = 5'd9;
      set_rd(5'd31, 5'd9);
      #1;
      chk($sformatf("t5_clear_busy_c%0d", i), 32'(clear_busy), 32'h1);
      chk($sformatf("t5_clear_done_c%0d", i), 32'(clear_done), (i == 32) ? 32'h1 : 32'h0);
      chk($sformatf("t5_nobypass_c%0d", i), rdata[31:0], 32'hA5A5A5A5);
      chk($sformatf("t5_rbusy_c%0d", i), 32'(rbusy), 32'h3);
      tick();
    end
    set_idle();
    for (int a = 0; a < 32; a++) begin
      set_rd(5'(a), 5'(a));
      #1;
      chk("t5_after_clear_busy", 32'(clear_busy), 32'h0);
      chk("t5_after_clear_done", 32'(clear_done), 32'h0);
      chk($sformatf("t5_zero_r%0d", a), rdata[31:0], 32'h0);
      chk($sformatf("t5_rbusy_r%0d", a), 32'(rbusy), 32'h0);
      tick();
    end

    // Reset in the middle of a clear
    for (int i = 1; i <= 4; i++) begin
      wen0 = 1; waddr0 = 5'(i); wdata0 = 32'hC0DE0000 | i;
      wen1 = 1; waddr1 = 5'(27 + i); wdata1 = 32'hBEEF0000 | i;
      tick();
    end
    set_idle();
    clear_req = 1;
    tick();
    clear_req = 0;
    set_rd(5'd30, 5'd4);
    for (int i = 1; i <= 9; i++) begin
      #1;
      chk($sformatf("t6_busy_c%0d", i), 32'(clear_busy), 32'h1);
      chk($sformatf("t6_done_c%0d", i), 32'(clear_done), 32'h0);
      tick();
    end
    rst_n = 0;
    #1;
    chk("t6_done_c10", 32'(clear_done), 32'h0);
    chk("t6_r30_before_reset", rdata[31:0], 32'hBEEF0003);
    tick();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      set_rd(5'(1 + i), 5'(28 + i));
      #1;
      chk("t6_idle", 32'(clear_busy), 32'h0);
      chk("t6_no_done", 32'(clear_done), 32'h0);
      chk($sformatf("t6_zero_lo%0d", i), rdata[31:0], 32'h0);
      chk($sformatf("t6_zero_hi%0d", i), rdata[63:32], 32'h0);
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
